// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: port indices and lock-state encoding.
package dmem_arb_pkg;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LOAD = 1'b1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of dmem_arbiter; lock1 exists only with DMEM_ARB_LOCK_EN.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic          stall0;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic          mem_we;
   logic [DW-1:0] mem_rd;
`ifdef DMEM_ARB_LOCK_EN
   logic          lock1;
`endif

   modport slave (
`ifdef DMEM_ARB_LOCK_EN
      input  lock1,
`endif
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, stall0, mem_a, mem_wd, mem_we
   );

   modport master (
`ifdef DMEM_ARB_LOCK_EN
      output lock1,
`endif
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, stall0, mem_a, mem_wd, mem_we
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a last-granted pointer; hold1 pins the grant to port 1.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic hold1,
   output logic gnt0,
   output logic gnt1
);

   logic last_q;

   // NOTE: every output gets a default before the ifs so no path leaves it unassigned (no latch).
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst) begin
         if (hold1) begin
            gnt1 = req1;
         end else if (req0 && req1) begin
            gnt0 = (last_q == PORT_LOAD);
            gnt1 = (last_q == PORT_CORE);
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= PORT_LOAD;
      end else if (gnt0) begin
         last_q <= PORT_CORE;
      end else if (gnt1) begin
         last_q <= PORT_LOAD;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core (port 0) and loader/debug (port 1), 1-cycle reads.
// Optional port-1 bus lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   logic          gnt0, gnt1;
   logic          hold1;
   logic [AW-1:0] mem_a_mux;
   logic [DW-1:0] mem_wd_mux;
   logic          mem_we_mux;
   logic [DW-1:0] rdata_q;
   logic          rvalid0_q, rvalid1_q;
   logic          rd_grant;

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rst   (rst),
      .req0  (bus.req0),
      .req1  (bus.req1),
      .hold1 (hold1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

`ifdef DMEM_ARB_LOCK_EN
   lock_state_e lock_q;

   // Port 1 keeps the bus while it both requests and asserts lock1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_q <= UNLOCKED;
      end else begin
         case (lock_q)
            UNLOCKED: if (gnt1 && bus.lock1) lock_q <= LOCKED;
            LOCKED:   if (!bus.lock1 || !bus.req1) lock_q <= UNLOCKED;
            default:  lock_q <= UNLOCKED;
         endcase
      end
   end

   assign hold1 = (lock_q == LOCKED);
`else
   assign hold1 = 1'b0;
`endif

   always_comb begin
      mem_a_mux  = '0;
      mem_wd_mux = '0;
      mem_we_mux = 1'b0;
      if (gnt0) begin
         mem_a_mux  = bus.addr0;
         mem_wd_mux = bus.wdata0;
         mem_we_mux = bus.we0;
      end else if (gnt1) begin
         mem_a_mux  = bus.addr1;
         mem_wd_mux = bus.wdata1;
         mem_we_mux = bus.we1;
      end
   end

   assign rd_grant = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);

   // NOTE: rdata is a single register, so it is reset; a RAM array would be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= gnt0 && !bus.we0;
         rvalid1_q <= gnt1 && !bus.we1;
         if (rd_grant) rdata_q <= bus.mem_rd;
      end
   end

   assign bus.gnt0    = gnt0;
   assign bus.gnt1    = gnt1;
   assign bus.stall0  = bus.req0 && !gnt0;
   assign bus.mem_a   = mem_a_mux;
   assign bus.mem_wd  = mem_wd_mux;
   assign bus.mem_we  = mem_we_mux;
   assign bus.rdata   = rdata_q;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: read returns are checked by a scoreboard monitor,
// grant/bus outputs are checked inline. Lock scenario runs with DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Word-addressed memory model: combinational read, write at the clock edge.
   logic [DW-1:0] mem [0:255];
   logic          mem_init_done = 1'b0;

   assign bus.mem_rd = mem[bus.mem_a[9:2]];

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
         mem_init_done <= 1'b1;
      end else if (bus.mem_we) begin
         mem[bus.mem_a[9:2]] <= bus.mem_wd;
      end
   end

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every rvalid pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      if (bus.rvalid0 || bus.rvalid1) begin
         if (sb_q.size() == 0) begin
            check("rvalid_spurious", {bus.rvalid1, bus.rvalid0}, 2'b00);
         end else begin
            mon_e = sb_q.pop_front();
            check("rvalid_port", {bus.rvalid1, bus.rvalid0}, mon_e.port ? 2'b10 : 2'b01);
            check("rdata", bus.rdata, mon_e.data);
         end
      end
   end

   task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic push(input logic port, input logic [DW-1:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      sb_q.push_back(e);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      set0(1'b1, 1'b1, 32'h10, 32'h1111_1111);
      set1(1'b1, 1'b1, 32'h14, 32'h2222_2222);
`ifdef DMEM_ARB_LOCK_EN
      bus.lock1 = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      // Reset state with both ports requesting.
      sample();
      check("rst_gnt0", bus.gnt0, 1'b0);
      check("rst_gnt1", bus.gnt1, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_stall0", bus.stall0, 1'b1);
      check("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
      check("rst_rdata", bus.rdata, 32'h0);
      tick();
      rst = 1'b1;

      // Single write from port 0.
      set0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      check("wr0_gnt0", bus.gnt0, 1'b1);
      check("wr0_gnt1", bus.gnt1, 1'b0);
      check("wr0_mem_we", bus.mem_we, 1'b1);
      check("wr0_mem_a", bus.mem_a, 32'h10);
      check("wr0_mem_wd", bus.mem_wd, 32'hDEAD_BEEF);
      check("wr0_stall0", bus.stall0, 1'b0);
      tick();

      // Read it back from port 0.
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      push(1'b0, 32'hDEAD_BEEF);
      sample();
      check("rd0_gnt0", bus.gnt0, 1'b1);
      check("rd0_mem_we", bus.mem_we, 1'b0);
      check("rd0_mem_a", bus.mem_a, 32'h10);
      tick();

      // Five idle cycles: bus parked at zero.
      set0(1'b0, 1'b1, 32'h44, 32'h5555_5555);
      for (int i = 0; i < 5; i++) begin
         sample();
         check("idle_mem_we", bus.mem_we, 1'b0);
         check("idle_mem_a", bus.mem_a, 32'h0);
         check("idle_mem_wd", bus.mem_wd, 32'h0);
         check("idle_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
         tick();
      end

      // Tie after a port-0 grant: port 1 wins; loser's write must not land.
      set0(1'b1, 1'b1, 32'h20, 32'hBAD0_BAD0);
      set1(1'b1, 1'b0, 32'h20, 32'h0);
      push(1'b1, 32'hA000_0008);
      sample();
      check("tie1_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
      check("tie1_stall0", bus.stall0, 1'b1);
      check("tie1_mem_we", bus.mem_we, 1'b0);
      check("tie1_mem_a", bus.mem_a, 32'h20);
      tick();

      // Port 1 write, then back-to-back reads across and within ports.
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      set1(1'b1, 1'b1, 32'h24, 32'h1234_5678);
      sample();
      check("wr1_gnt1", bus.gnt1, 1'b1);
      check("wr1_mem_we", bus.mem_we, 1'b1);
      check("wr1_mem_wd", bus.mem_wd, 32'h1234_5678);
      tick();
      set1(1'b1, 1'b0, 32'h24, 32'h0);
      push(1'b1, 32'h1234_5678);
      sample();
      check("rd1_gnt1", bus.gnt1, 1'b1);
      tick();
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      push(1'b0, 32'hDEAD_BEEF);
      sample();
      check("b2b_a_gnt0", bus.gnt0, 1'b1);
      tick();
      set0(1'b1, 1'b0, 32'h20, 32'h0);
      push(1'b0, 32'hA000_0008);
      sample();
      check("b2b_b_gnt0", bus.gnt0, 1'b1);
      tick();
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;

      // Four-cycle tie after reset alternates 0,1,0,1.
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      set1(1'b1, 1'b0, 32'h24, 32'h0);
      for (int c = 0; c < 4; c++) begin
         if (c % 2 == 0) push(1'b0, 32'hDEAD_BEEF);
         else            push(1'b1, 32'h1234_5678);
         sample();
         check("rr_gnt0", bus.gnt0, (c % 2 == 0));
         check("rr_gnt1", bus.gnt1, (c % 2 == 1));
         check("rr_stall0", bus.stall0, (c % 2 == 1));
         tick();
      end

      // Read granted, then reset in the return cycle: the read is dropped.
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      check("rstrd_gnt0", bus.gnt0, 1'b1);
      tick();
      rst = 1'b0;
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      check("rstrd_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
      check("rstrd_rdata", bus.rdata, 32'h0);
      tick();
      rst = 1'b1;
      sample();
      check("rstrd_post_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
      tick();
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      set1(1'b1, 1'b0, 32'h24, 32'h0);
      push(1'b0, 32'hDEAD_BEEF);
      sample();
      check("rstrd_tie_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
      tick();
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

`ifdef DMEM_ARB_LOCK_EN
      // Port 1 locks the bus for three tie cycles, then releases.
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      set1(1'b1, 1'b0, 32'h24, 32'h0);
      bus.lock1 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         push(1'b1, 32'h1234_5678);
         sample();
         check("lock_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
         check("lock_stall0", bus.stall0, 1'b1);
         tick();
      end
      bus.lock1 = 1'b0;
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      set0(1'b1, 1'b0, 32'h10, 32'h0);
      set1(1'b1, 1'b0, 32'h24, 32'h0);
      push(1'b0, 32'hDEAD_BEEF);
      sample();
      check("unlock_tie_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
      tick();
      set0(1'b0, 1'b0, 32'h0, 32'h0);
      set1(1'b0, 1'b0, 32'h0, 32'h0);
`endif

      repeat (3) tick();
      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning the data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  transaction request (port 0 = core load/store, port 1 = loader/debug).
REQ-006 SHALL have ports we0/we1  input  1  write enable of the request.
REQ-007 SHALL have ports addr0/addr1  input  AW  byte address.
REQ-008 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  request accepted this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have port rdata  output  DW  registered read data, shared by both ports.
REQ-012 SHALL have port stall0  output  1  equals req0 AND NOT gnt0; freezes the core PC.
REQ-013 SHALL have ports mem_a  output AW, mem_wd  output DW, mem_we  output 1, driving the data memory.
REQ-014 SHALL have port mem_rd  input  DW  combinational read data from the data memory.

Function
REQ-015 SHALL grant at most one port per cycle; grant is combinational from req0/req1 and the priority pointer.
REQ-016 SHALL resolve single requests immediately: only reqN high -> gntN high the same cycle.
REQ-017 SHALL resolve simultaneous requests round-robin: the port not granted most recently wins; after reset port 0 wins the first tie.
REQ-018 SHALL update the priority pointer to the granted port at each clock edge where any grant is high; it holds otherwise.
REQ-019 SHALL drive mem_a/mem_wd/mem_we from the granted port; with no grant, mem_we = 0 and mem_a/mem_wd = 0.
REQ-020 SHALL commit writes at the rising edge ending the grant cycle (via the memory); writes produce no rvalid.
REQ-021 SHALL capture mem_rd into rdata at the edge ending a read-grant cycle and pulse rvalidN for exactly the next cycle; read latency is 1 cycle.
REQ-022 SHALL hold rdata between reads; back-to-back reads from either port yield one rvalid per grant cycle.
REQ-023 SHALL treat each grant cycle as one complete transaction; a requester keeps reqN high to issue further transactions.
REQ-024 SHALL ignore we/addr/wdata of a non-granted port.

Reset
REQ-025 SHALL, while rst = 0, force the pointer to "port 1 last", rdata = 0, rvalid0 = rvalid1 = 0, lock state = UNLOCKED, independent of clk.
REQ-026 SHALL force gnt0 = gnt1 = 0 and mem_we = 0 combinationally while rst = 0; stall0 = req0 then.
REQ-027 SHALL drop a read in flight when reset asserts mid-operation: no rvalid after reset release.

Configuration
REQ-028 SHALL, with macro DMEM_ARB_LOCK_EN defined, add input lock1 (1 bit) and a two-state FSM UNLOCKED/LOCKED: UNLOCKED->LOCKED when gnt1 and lock1 at an edge; LOCKED->UNLOCKED at the first edge with lock1 = 0 or req1 = 0; while LOCKED port 1 wins every cycle it requests and port 0 is never granted.
REQ-029 SHALL, without DMEM_ARB_LOCK_EN, have no lock1 port and no lock FSM; arbitration is pure round-robin.

Structure
REQ-030 SHALL place the port-index constants (PORT_CORE = 0, PORT_LOAD = 1) and the lock-state encodings (UNLOCKED = 0, LOCKED = 1) in the shared package dmem_arb_pkg.
REQ-031 SHALL implement the two-input round-robin grant logic with its pointer register as sub-module rr_arb2; the read-return register and mux stay in dmem_arbiter.

Verification
REQ-032 SHALL cover: after reset, req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF -> gnt0 = 1 same cycle, mem_we = 1, mem_a = 0x10, no rvalid0.
REQ-033 SHALL cover: req0 read 0x10 next cycle -> rvalid0 pulses one cycle later with rdata = 0xDEADBEEF; rvalid1 stays 0.
REQ-034 SHALL cover: req0 = req1 = 1 for 4 cycles after reset -> grants alternate 0,1,0,1; stall0 = 1 in cycles 2 and 4 only.
REQ-035 SHALL cover: rst asserted in the cycle after a read grant -> rvalid0 = 0, rdata = 0 immediately; after release, first tie goes to port 0.
REQ-036 SHALL cover, with DMEM_ARB_LOCK_EN: req1 = lock1 = 1 for 3 cycles with req0 = 1 -> gnt1 all 3 cycles, stall0 = 1; lock1 drops -> next tie goes to port 0.
REQ-037 SHALL cover: no requests -> mem_we = 0, mem_a = 0, pointer unchanged across 5 idle cycles.
